// File: rtl/bus_sequencer.sv
// Micro-step controller for the shared 32-bit datapath bus. It sequences one register-to-register
// ALU command through bus drive, Y/Z latch, ALU start and register-file write-back steps.
`timescale 1ns/1ps
module bus_sequencer #(
  parameter int REGW    = 4,
  parameter int OPW     = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [REGW-1:0] ra_sel,
  input  logic [REGW-1:0] rb_sel,
  input  logic [REGW-1:0] rd_sel,
  input  logic            alu_done,
  output logic            ready,
  output logic            done,
  output logic            err,
  output logic            RAout,
  output logic            RBout,
  output logic            RZout,
  output logic [REGW-1:0] reg_out_sel,
  output logic            Yin,
  output logic            Zin,
  output logic [OPW-1:0]  alu_op,
  output logic            alu_start,
  output logic            Rin,
  output logic [REGW-1:0] reg_in_sel
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [OPW-1:0] OP_MUL    = OPW'(5'h0E);
  localparam logic [OPW-1:0] OP_DIV    = OPW'(5'h0F);
  localparam logic [OPW-1:0] OP_NOT    = OPW'(5'h10);
  localparam logic [OPW-1:0] OP_NEG    = OPW'(5'h11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TA,
    S_TB,
    S_WAIT,
    S_WB,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [OPW-1:0]  op_q;
  logic [REGW-1:0] ra_q, rb_q, rd_q;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            unary_in;
  logic            multi_q;
  logic            wait_expire;

  assign accept      = (state == S_IDLE) && start;
  assign unary_in    = (op == OP_NOT) || (op == OP_NEG);
  assign multi_q     = (op_q == OP_MUL) || (op_q == OP_DIV);
  // alu_done on the final permitted WAIT cycle wins over the timeout
  assign wait_expire = (state == S_WAIT) && !alu_done && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q <= op;
        ra_q <= ra_sel;
        rb_q <= rb_sel;
        rd_q <= rd_sel;
      end
      if (state == S_TB)
        wait_cnt <= '0;
      else if (state == S_WAIT && !alu_done)
        wait_cnt <= wait_cnt + CW'(1);
      if (accept)
        err <= 1'b0;
      else if (wait_expire)
        err <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    done        = 1'b0;
    RAout       = 1'b0;
    RBout       = 1'b0;
    RZout       = 1'b0;
    reg_out_sel = '0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    alu_op      = '0;
    alu_start   = 1'b0;
    Rin         = 1'b0;
    reg_in_sel  = '0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start)
          state_next = unary_in ? S_TB : S_TA;
      end
      S_TA: begin
        RAout       = 1'b1;
        Yin         = 1'b1;
        reg_out_sel = ra_q;
        state_next  = S_TB;
      end
      S_TB: begin
        RBout       = 1'b1;
        reg_out_sel = rb_q;
        alu_op      = op_q;
        if (multi_q) begin
          alu_start  = 1'b1;
          state_next = S_WAIT;
        end else begin
          Zin        = 1'b1;
          state_next = S_WB;
        end
      end
      S_WAIT: begin
        alu_op = op_q;
        Zin    = alu_done;
        if (alu_done)
          state_next = S_WB;
        else if (wait_expire)
          state_next = S_DONE;
      end
      S_WB: begin
        RZout      = 1'b1;
        Rin        = 1'b1;
        reg_in_sel = rd_q;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed scenarios plus randomized commands checked every cycle
// against a per-command expected-output timeline built from the command rules.
`timescale 1ns/1ps
module tb_bus_sequencer;
  localparam int REGW    = 4;
  localparam int OPW     = 5;
  localparam int TIMEOUT = 8;

  logic            clock = 1'b0;
  logic            resetn;
  logic            start;
  logic [OPW-1:0]  op;
  logic [REGW-1:0] ra_sel, rb_sel, rd_sel;
  logic            alu_done;
  logic            ready, done, err, RAout, RBout, RZout, Yin, Zin, alu_start, Rin;
  logic [REGW-1:0] reg_out_sel, reg_in_sel;
  logic [OPW-1:0]  alu_op;

  typedef struct packed {
    logic            ready, done, err, RAout, RBout, RZout;
    logic [REGW-1:0] reg_out_sel;
    logic            Yin, Zin;
    logic [OPW-1:0]  alu_op;
    logic            alu_start, Rin;
    logic [REGW-1:0] reg_in_sel;
  } outv_t;

  outv_t act;
  outv_t expQ[$];
  int    checkCount = 0;
  int    passCount  = 0;
  int    sinceAccept = -1;
  int    lastLat = -1;
  int    cycleNo = 0;
  logic  errModel = 1'b0;

  bus_sequencer #(.REGW(REGW), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rd_sel(rd_sel), .alu_done(alu_done),
    .ready(ready), .done(done), .err(err), .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .reg_out_sel(reg_out_sel), .Yin(Yin), .Zin(Zin), .alu_op(alu_op),
    .alu_start(alu_start), .Rin(Rin), .reg_in_sel(reg_in_sel)
  );

  assign act = {ready, done, err, RAout, RBout, RZout, reg_out_sel, Yin, Zin,
                alu_op, alu_start, Rin, reg_in_sel};

  always #5 clock = ~clock;

  function automatic outv_t idleExp(input logic e);
    outv_t o;
    o = '0;
    o.ready = 1'b1;
    o.err = e;
    return o;
  endfunction

  function automatic string fmt(input outv_t o);
    return $sformatf("rdy=%0b done=%0b err=%0b RA=%0b RB=%0b RZ=%0b osel=%0d Yin=%0b Zin=%0b aop=%h astart=%0b Rin=%0b isel=%0d",
                     o.ready, o.done, o.err, o.RAout, o.RBout, o.RZout, o.reg_out_sel,
                     o.Yin, o.Zin, o.alu_op, o.alu_start, o.Rin, o.reg_in_sel);
  endfunction

  task automatic checkOutput(input string name, input outv_t got, input outv_t want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got {%s} want {%s}", name, fmt(got), fmt(want));
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    checkCount++;
    if (got == want) passCount++;
    else $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Per-cycle compare against the expected timeline; also measures start-to-done latency.
  task automatic compareLoop();
    forever begin
      @(negedge clock);
      cycleNo++;
      if (!resetn) begin
        sinceAccept = -1;
      end else begin
        if (sinceAccept >= 0) sinceAccept++;
        if (done) begin
          lastLat = sinceAccept;
          sinceAccept = -1;
        end
        if (ready && start) sinceAccept = 0;
      end
      checkVal("one_bus_driver", int'($countones({RAout, RBout, RZout}) <= 1), 1);
      if (expQ.size() > 0)
        checkOutput($sformatf("cycle%0d", cycleNo), act, expQ.pop_front());
    end
  endtask

  task automatic randomizeFields();
    op     = OPW'($urandom_range(31));
    ra_sel = REGW'($urandom_range(15));
    rb_sel = REGW'($urandom_range(15));
    rd_sel = REGW'($urandom_range(15));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      randomizeFields();
      alu_done = ($urandom_range(3) == 0);
      expQ.push_back(idleExp(errModel));
    end
  endtask

  // d = cycles from alu_start to alu_done (multi ops); cut > 0 stops after that many command cycles.
  task automatic applyStimulus(input logic [OPW-1:0] cop, input logic [REGW-1:0] cra,
                               input logic [REGW-1:0] crb, input logic [REGW-1:0] crd,
                               input int d, input bit hold, input int cut);
    outv_t seq[$];
    bit    adv[$];
    bit    noiseOk[$];
    outv_t o;
    bit    multi, unary, ok;
    int    n;
    multi = (cop == 5'h0E) || (cop == 5'h0F);
    unary = (cop == 5'h10) || (cop == 5'h11);
    @(posedge clock); #1;
    start = 1'b1;
    op = cop; ra_sel = cra; rb_sel = crb; rd_sel = crd;
    alu_done = ($urandom_range(3) == 0);
    expQ.push_back(idleExp(errModel));
    errModel = 1'b0;
    if (!unary) begin
      o = '0; o.RAout = 1'b1; o.Yin = 1'b1; o.reg_out_sel = cra;
      seq.push_back(o); adv.push_back(1'b0); noiseOk.push_back(1'b1);
    end
    o = '0; o.RBout = 1'b1; o.reg_out_sel = crb; o.alu_op = cop;
    o.Zin = !multi; o.alu_start = multi;
    seq.push_back(o); adv.push_back(1'b0); noiseOk.push_back(1'b1);
    ok = 1'b1;
    if (multi) begin
      ok = (d <= TIMEOUT);
      n  = ok ? d : TIMEOUT;
      for (int i = 1; i <= n; i++) begin
        o = '0; o.alu_op = cop; o.Zin = (i == d);
        seq.push_back(o); adv.push_back(i == d); noiseOk.push_back(1'b0);
      end
    end
    if (ok) begin
      o = '0; o.RZout = 1'b1; o.Rin = 1'b1; o.reg_in_sel = crd;
      seq.push_back(o); adv.push_back(1'b0); noiseOk.push_back(1'b1);
    end else begin
      errModel = 1'b1;
    end
    o = '0; o.done = 1'b1; o.err = errModel;
    seq.push_back(o); adv.push_back(1'b0); noiseOk.push_back(1'b1);
    for (int i = 0; i < seq.size() && (cut == 0 || i < cut); i++) begin
      @(posedge clock); #1;
      start = hold;
      if (hold || $urandom_range(1) == 1) randomizeFields();
      alu_done = adv[i] | (noiseOk[i] & ($urandom_range(3) == 0));
      expQ.push_back(seq[i]);
    end
  endtask

  task automatic checkLatency(input string name, input int want);
    @(negedge clock); #1;
    checkVal(name, lastLat, want);
  endtask

  initial begin
    logic [OPW-1:0] rop;
    int sel;
    fork
      compareLoop();
    join_none
    resetn = 1'b0; start = 1'b0; alu_done = 1'b0;
    op = '0; ra_sel = '0; rb_sel = '0; rd_sel = '0;
    #2;
    checkOutput("reset_state", act, idleExp(1'b0));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    idleCycles(2);

    applyStimulus(5'h03, 4'd2, 4'd5, 4'd7, 0, 1'b0, 0);
    checkLatency("lat_add", 4);
    applyStimulus(5'h10, 4'd0, 4'd3, 4'd4, 0, 1'b0, 0);
    checkLatency("lat_not", 3);
    applyStimulus(5'h0E, 4'd6, 4'd1, 4'd9, 3, 1'b0, 0);
    checkLatency("lat_mul", 7);

    applyStimulus(5'h0F, 4'd8, 4'd2, 4'd12, TIMEOUT + 4, 1'b0, 0);
    checkLatency("lat_div_timeout", 3 + TIMEOUT);
    idleCycles(2);
    @(negedge clock); #1;
    checkVal("err_sticky", int'(err), 1);
    applyStimulus(5'h03, 4'd1, 4'd1, 4'd2, 0, 1'b0, 0);
    checkLatency("lat_add_after_err", 4);
    checkVal("err_cleared", int'(err), 0);

    applyStimulus(5'h0F, 4'd3, 4'd4, 4'd5, TIMEOUT, 1'b0, 0);
    checkLatency("lat_div_at_limit", 4 + TIMEOUT);
    applyStimulus(5'h0E, 4'd3, 4'd4, 4'd5, 1, 1'b0, 0);
    checkLatency("lat_mul_fast", 5);
    applyStimulus(5'h11, 4'd0, 4'd14, 4'd15, 0, 1'b0, 0);
    checkLatency("lat_neg", 3);

    applyStimulus(5'h03, 4'd1, 4'd2, 4'd3, 0, 1'b1, 0);
    applyStimulus(5'h05, 4'd9, 4'd10, 4'd11, 0, 1'b0, 0);
    checkLatency("lat_back_to_back", 4);

    applyStimulus(5'h0E, 4'd1, 4'd2, 4'd3, 100, 1'b0, 4);
    @(posedge clock); #1;
    start = 1'b0; alu_done = 1'b0;
    #2 resetn = 1'b0;
    #1 checkOutput("async_reset_in_wait", act, idleExp(1'b0));
    errModel = 1'b0;
    expQ.push_back(idleExp(1'b0));
    @(posedge clock); #1;
    expQ.push_back(idleExp(1'b0));
    @(posedge clock); #1;
    resetn = 1'b1;
    expQ.push_back(idleExp(1'b0));
    idleCycles(3);
    applyStimulus(5'h03, 4'd7, 4'd8, 4'd9, 0, 1'b0, 0);
    checkLatency("lat_add_after_reset", 4);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(9);
      case (sel)
        0: rop = 5'h0E;
        1: rop = 5'h0F;
        2: rop = 5'h10;
        3: rop = 5'h11;
        default: rop = OPW'($urandom_range(31));
      endcase
      applyStimulus(rop, REGW'($urandom_range(15)), REGW'($urandom_range(15)),
                    REGW'($urandom_range(15)), $urandom_range(1, TIMEOUT + 3),
                    ($urandom_range(3) == 0), 0);
      idleCycles($urandom_range(2));
    end

    idleCycles(2);
    @(negedge clock); #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
Micro-step controller for the shared 32-bit datapath bus with the RA/RB/RZ source drivers. It takes one register-to-register ALU command and sequences it over several clock cycles: bus drive enables, Y/Z latch enables, ALU start, and register-file write-back. Multi-cycle ALU ops (MUL/DIV) are handled with a done handshake and a timeout. It sits between instruction decode and the bus/register file, and guarantees at most one bus driver per cycle.

Parameters:
REGW, 4, register index width (16 GPRs)
OPW, 5, ALU opcode width
TIMEOUT, 64, max cycles waiting for alu_done before abort (>=2)

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
start  in  1  command valid; accepted only when ready=1
op  in  OPW  ALU opcode
ra_sel  in  REGW  source A register index
rb_sel  in  REGW  source B register index
rd_sel  in  REGW  destination register index
alu_done  in  1  multi-cycle ALU result valid (1-cycle pulse)
ready  out  1  idle, can accept a command
done  out  1  1-cycle completion pulse
err  out  1  last command aborted by timeout (sticky)
RAout  out  1  RA drives bus
RBout  out  1  RB drives bus
RZout  out  1  Z drives bus
reg_out_sel  out  REGW  register-file read index feeding RA/RB
Yin  out  1  latch bus into Y
Zin  out  1  latch ALU result into Z
alu_op  out  OPW  latched opcode to ALU
alu_start  out  1  1-cycle start pulse for multi-cycle ALU
Rin  out  1  register-file write enable from bus
reg_in_sel  out  REGW  write-back index

Behaviour:
- Reset (async, resetn=0): state=IDLE; ready=1; all other outputs 0, including the indices and alu_op. Reset mid-command abandons it with no write-back and no done.
- On an accepted start (IDLE, start=1 at a rising edge), latch op/ra_sel/rb_sel/rd_sel. start is ignored in every other state, and the latches do not change.
- Op classes: MUL=5'h0E and DIV=5'h0F are multi-cycle. NOT=5'h10 and NEG=5'h11 are unary and use RB only. All others are binary single-cycle.
- States and outputs are decoded from the registered state. Zin in WAIT is the only combinational output.
  - IDLE: ready=1. Start goes to TA (binary/multi) or TB (unary).
  - TA: RAout=1, Yin=1, reg_out_sel=ra. Goes to TB.
  - TB: RBout=1, reg_out_sel=rb, alu_op=op. Single-cycle op: Zin=1, go to WB. Multi-cycle op: alu_start=1, go to WAIT.
  - WAIT: no bus driver; alu_op held; Zin=alu_done. If alu_done=1, go to WB. Otherwise increment the wait counter. When the counter reaches TIMEOUT-1, set err=1 and go to DONE (no WB).
  - WB: RZout=1, Rin=1, reg_in_sel=rd. Goes to DONE.
  - DONE: done=1. Goes to IDLE.
- The wait counter clears on entry to WAIT. alu_done on the same cycle as the timeout limit counts as success (no err).
- err clears on the next accepted start. It stays high through the DONE of an aborted command.
- Invariant: RAout+RBout+RZout <= 1 in every cycle. Rin only in WB. Yin only in TA.
- Latency, start edge to done high:
  - binary single: 4 cycles (TA,TB,WB,DONE)
  - unary: 3 cycles
  - multi: 4 + N cycles, where N = WAIT cycles including the alu_done cycle
- Back-to-back: ready returns 1 the cycle after DONE. Minimum command spacing is latency+1.
- alu_done outside WAIT is ignored.

Test Plan:
- Reset then ADD (op=5'h03, ra=2, rb=5, rd=7): cycle1 RAout=1,Yin=1,reg_out_sel=2 -> cycle2 RBout=1,Zin=1,reg_out_sel=5 -> cycle3 RZout=1,Rin=1,reg_in_sel=7 -> cycle4 done=1, err=0 -> cycle5 ready=1.
- NOT (op=5'h10, rb=3, rd=4): no TA. TB at cycle1, WB at cycle2, done at cycle3. Yin never asserted.
- MUL (op=5'h0E) with alu_done pulsed 3 cycles after alu_start: alu_start a single pulse in TB. Zin=1 exactly on the alu_done cycle, then WB, then done. Total 7 cycles.
- DIV with TIMEOUT=8 and alu_done never asserted: after 8 WAIT cycles, done=1 with err=1 and Rin never high. The next accepted start clears err.
- start held high continuously during an ADD with changing ra/rb/rd: the second command starts only after ready=1 and uses the values sampled at that edge. The first command's indices are unaffected.
- resetn dropped asynchronously during WAIT of a MUL: all outputs go to 0 immediately and ready=1. No done or Rin after release. A subsequent ADD completes normally.
- All scenarios: assertion that at most one of RAout/RBout/RZout is high every cycle.
